// File: rtl/urv_irq_timer.sv
// IRQ synchronise/pend/mask and prescaled compare timer feeding the exception unit.
// Optional rising-edge IRQ mode is compiled in with `define URV_IRQ_EDGE_EN.

module urv_irq_line #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
`ifdef URV_IRQ_EDGE_EN
  input  logic edge_i,
`endif
  output logic set_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
  end

`ifdef URV_IRQ_EDGE_EN
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) prev_q <= 1'b0;
    else        prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign set_o = edge_i ? (sync_q[SYNC_STAGES-1] & ~prev_q) : sync_q[SYNC_STAGES-1];
`else
  assign set_o = sync_q[SYNC_STAGES-1];
`endif

endmodule

module urv_irq_timer #(
  parameter int NUM_IRQ     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMER_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [4:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  input  logic               bus_we_i,
  input  logic               bus_re_i,
  output logic [31:0]        bus_rdata_o,
  output logic               bus_rvalid_o,
  output logic [31:0]        exp_irq_o,
  output logic               exp_tick_o
);

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_CNT  = 3'd1;
  localparam logic [2:0] A_CMP  = 3'd2;
  localparam logic [2:0] A_PEND = 3'd3;
  localparam logic [2:0] A_MASK = 3'd4;
  localparam logic [2:0] A_EDGE = 3'd5;

  logic [2:0]             sel;
  logic                   wr_ctrl, wr_cnt, wr_cmp, wr_pend, wr_mask;
  logic                   timer_en;
  logic [7:0]             psc, psc_cnt;
  logic                   step;
  logic [TIMER_WIDTH-1:0] cnt, cmp;
  logic [NUM_IRQ-1:0]     set, clr, pend, mask, irq_q;
  logic [NUM_IRQ-1:0]     edge_q;
  logic [31:0]            rd_mux;
  logic                   unused_bits;

  assign sel     = bus_addr_i[4:2];
  assign wr_ctrl = bus_we_i && (sel == A_CTRL);
  assign wr_cnt  = bus_we_i && (sel == A_CNT);
  assign wr_cmp  = bus_we_i && (sel == A_CMP);
  assign wr_pend = bus_we_i && (sel == A_PEND);
  assign wr_mask = bus_we_i && (sel == A_MASK);

  assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i};

  // ---------------------------------------------------------------- timer
  assign step = timer_en && (psc_cnt == psc);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      timer_en   <= 1'b0;
      psc        <= '0;
      psc_cnt    <= '0;
      cnt        <= '0;
      cmp        <= '0;
      exp_tick_o <= 1'b0;
    end else begin
      exp_tick_o <= 1'b0;
      // >= rather than == so a prescale shrunk below the live count still wraps
      if (!timer_en || psc_cnt >= psc) psc_cnt <= '0;
      else                             psc_cnt <= psc_cnt + 8'd1;
      if (wr_cnt) begin
        cnt <= bus_wdata_i[TIMER_WIDTH-1:0];
      end else if (step) begin
        if (cnt == cmp) begin
          cnt        <= '0;
          exp_tick_o <= 1'b1;
        end else begin
          cnt <= cnt + TIMER_WIDTH'(1);
        end
      end
      if (wr_ctrl) begin
        timer_en <= bus_wdata_i[0];
        psc      <= bus_wdata_i[15:8];
      end
      if (wr_cmp) cmp <= bus_wdata_i[TIMER_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------- irq lines
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    urv_irq_line #(.SYNC_STAGES(SYNC_STAGES)) u_line (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .irq_i  (irq_i[i]),
`ifdef URV_IRQ_EDGE_EN
      .edge_i (edge_q[i]),
`endif
      .set_o  (set[i])
    );
  end

`ifdef URV_IRQ_EDGE_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                             edge_q <= '0;
    else if (bus_we_i && (sel == A_EDGE))   edge_q <= bus_wdata_i[NUM_IRQ-1:0];
  end
`else
  assign edge_q = '0;
`endif

  assign clr = wr_pend ? bus_wdata_i[NUM_IRQ-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend  <= '0;
      mask  <= '0;
      irq_q <= '0;
    end else begin
      // a line asserting in the same cycle as its W1C stays pending
      pend  <= (pend & ~clr) | set;
      irq_q <= pend & mask;
      if (wr_mask) mask <= bus_wdata_i[NUM_IRQ-1:0];
    end
  end

  assign exp_irq_o = 32'(irq_q);

  // ---------------------------------------------------------------- read port
  always_comb begin
    rd_mux = '0;
    case (sel)
      A_CTRL: rd_mux = {16'd0, psc, 7'd0, timer_en};
      A_CNT:  rd_mux = 32'(cnt);
      A_CMP:  rd_mux = 32'(cmp);
      A_PEND: rd_mux = 32'(pend);
      A_MASK: rd_mux = 32'(mask);
`ifdef URV_IRQ_EDGE_EN
      A_EDGE: rd_mux = 32'(edge_q);
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus_rdata_o  <= '0;
      bus_rvalid_o <= 1'b0;
    end else begin
      bus_rvalid_o <= bus_re_i;
      if (bus_re_i) bus_rdata_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_urv_irq_timer.sv
// Scoreboard bench for urv_irq_timer: reads are queued with expected data and
// checked by a monitor on bus_rvalid_o; tick/irq outputs are checked per cycle.

module tb_urv_irq_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] irq = '0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] rdata, exp_irq;
  logic        rvalid, tick;

  int vectors = 0;
  int miscompares = 0;
  int rd_id = 0;

  typedef struct {
    logic [31:0] exp;
    int          id;
  } rd_exp_t;

  rd_exp_t sb[$];

  always #5 clk = ~clk;

  urv_irq_timer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .irq_i        (irq),
    .bus_addr_i   (addr),
    .bus_wdata_i  (wdata),
    .bus_we_i     (we),
    .bus_re_i     (re),
    .bus_rdata_o  (rdata),
    .bus_rvalid_o (rvalid),
    .exp_irq_o    (exp_irq),
    .exp_tick_o   (tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // read monitor: pops the oldest expectation whenever read data is presented
  always @(negedge clk) begin
    if (rvalid) begin
      rd_exp_t e;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got rvalid data %h expected no read", rdata);
      end else begin
        e = sb.pop_front();
        chk($sformatf("rd%0d", e.id), rdata, e.exp);
      end
    end
  end

  // one bus cycle: inputs change on the falling edge, sampled on the next rising edge
  task automatic cyc(input logic w, input logic r, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] ex);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    if (r) begin
      sb.push_back('{ex, rd_id});
      rd_id++;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d, '0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] ex);
    cyc(1'b0, 1'b1, a, '0, ex);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 5'd0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state and all offsets read zero
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_irq", exp_irq, 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    for (int a = 0; a < 8; a++) rd(5'(a * 4), 32'h0);
    idle(2);

    // register read-back, unmapped offset, read-old-on-simultaneous write
    wr(5'd8, 32'hA5);
    rd(5'd8, 32'hA5);
    wr(5'd24, 32'hFFFF_FFFF);
    rd(5'd24, 32'h0);
    cyc(1'b1, 1'b1, 5'd8, 32'h3, 32'hA5);
    rd(5'd8, 32'h3);
    wr(5'd0, 32'h0000_AB00);
    rd(5'd0, 32'h0000_AB00);
    wr(5'd0, 32'h0);

    // P=0, CMP=3: CNT 0,1,2,3,0.. and a tick every 4th cycle
    wr(5'd0, 32'h1);
    for (int i = 1; i <= 12; i++) begin
      rd(5'd4, 32'((i - 1) % 4));
      chk("tick_p0", 32'(tick), 32'(i >= 2 && (i - 1) % 4 == 0));
    end
    wr(5'd0, 32'h0);
    idle(2);
    chk("tick_off", 32'(tick), 32'h0);
    rd(5'd4, 32'h1);
    idle(2);
    rd(5'd4, 32'h1);

    // P=2, CMP=0: tick every 3rd cycle; a CNT write on a step cycle suppresses it
    wr(5'd8, 32'h0);
    wr(5'd4, 32'h0);
    wr(5'd0, 32'h0201);
    for (int i = 1; i <= 13; i++) begin
      cyc(i == 12, i == 13, 5'd4, 32'h5, 32'h5);
      chk("tick_p2", 32'(tick), 32'(i >= 4 && (i - 1) % 3 == 0 && i != 13));
    end
    wr(5'd0, 32'h0);
    idle(1);
    rd(5'd4, 32'h5);

    // level IRQ 0, masked in: latency, W1C while held, clear after drop
    wr(5'd16, 32'h1);
    idle(1);
    irq[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk("irq0_lat", exp_irq, 32'(i == 4));
    end
    wr(5'd12, 32'h1);
    rd(5'd12, 32'h1);
    chk("irq0_repend", exp_irq, 32'h1);
    idle(1);
    irq[0] = 1'b0;
    idle(3);
    wr(5'd12, 32'h1);
    idle(1);
    chk("irq0_hold", exp_irq, 32'h1);
    rd(5'd12, 32'h0);
    chk("irq0_clr", exp_irq, 32'h0);

    // IRQ 3 pending while masked out, then unmask / re-mask
    wr(5'd16, 32'h0);
    idle(1);
    irq[3] = 1'b1;
    idle(5);
    rd(5'd12, 32'h8);
    chk("irq3_masked", exp_irq, 32'h0);
    wr(5'd16, 32'h8);
    idle(1);
    chk("irq3_unmask0", exp_irq, 32'h0);
    idle(1);
    chk("irq3_unmask1", exp_irq, 32'h8);
    wr(5'd16, 32'h0);
    idle(2);
    chk("irq3_remask", exp_irq, 32'h0);
    rd(5'd12, 32'h8);
    irq[3] = 1'b0;
    idle(4);
    wr(5'd12, 32'h8);
    idle(1);
    rd(5'd12, 32'h0);

`ifdef URV_IRQ_EDGE_EN
    // edge line 1: one-clock pulse latches, held-high line stays cleared after W1C
    wr(5'd20, 32'h2);
    rd(5'd20, 32'h2);
    idle(1);
    irq[1] = 1'b1;
    idle(1);
    irq[1] = 1'b0;
    idle(5);
    rd(5'd12, 32'h2);
    idle(4);
    rd(5'd12, 32'h2);
    idle(1);
    irq[1] = 1'b1;
    idle(5);
    wr(5'd12, 32'h2);
    idle(2);
    rd(5'd12, 32'h0);
    idle(3);
    rd(5'd12, 32'h0);
    irq[1] = 1'b0;
`else
    wr(5'd20, 32'hFFFF_FFFF);
    rd(5'd20, 32'h0);
`endif

    // asynchronous reset while a read is in flight
    wr(5'd8, 32'h55);
    @(negedge clk);
    we = 1'b0; addr = 5'd8; re = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    re = 1'b0;
    chk("arst_rvalid", 32'(rvalid), 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    rd(5'd8, 32'h0);
    idle(3);

    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL rd_missing: got %0d outstanding reads expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
